pwm_capture: RTL and testbench
==============================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter: COUNTER_WIDTH, 32, width of all cycle counters and measurement outputs.
REQ-002 Parameter: SYNC_STAGES, 2 (min 2), synchronizer depth on pwm_in.
REQ-003 clk  input  1  system clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  capture enable; low forces IDLE.
REQ-006 polarity  input  1  0: active level = pwm_in high; 1: active level = pwm_in low; change only while en=0.
REQ-007 pwm_in  input  1  asynchronous PWM gate signal under measurement.
REQ-008 timeout  input  COUNTER_WIDTH  stuck-detect limit in clk cycles; 0 disables.
REQ-009 period  output  COUNTER_WIDTH  last measured active-edge to active-edge period, clk cycles.
REQ-010 high_time  output  COUNTER_WIDTH  last measured active-level duration, clk cycles.
REQ-011 valid  output  1  one-cycle pulse when period/high_time update.
REQ-012 stuck  output  1  level, no edge within timeout cycles.
REQ-013 stuck_level  output  1  active level (post-polarity) at stuck entry.

Function
REQ-014 pwm_in passes SYNC_STAGES flops; level = sync_out XOR polarity; prev_level register gives rise = level & !prev_level, fall = !level & prev_level.
REQ-015 FSM states: IDLE, ARM, HIGH, LOW, STUCK.
REQ-016 en=0 in any state -> IDLE next cycle; in-progress measurement discarded, valid=0, stuck=0, period/high_time hold.
REQ-017 IDLE -> ARM when en=1.
REQ-018 ARM -> HIGH on rise only; level already high on arming waits for a low first (no spurious edge after reset/enable).
REQ-019 On rise entering HIGH: cnt <= 1.
REQ-020 In HIGH/LOW: cnt <= cnt+1 each cycle, saturating at all-ones; saturation sets sat flag.
REQ-021 HIGH, fall: hcap <= cnt, -> LOW.
REQ-022 LOW, rise: if sat=0, period <= cnt, high_time <= hcap, valid <= 1; cnt <= 1, sat <= 0, -> HIGH; sat=1 suppresses update and valid.
REQ-023 Result: level high H cycles, low L cycles -> period = H+L, high_time = H.
REQ-024 Latency: valid and new outputs registered SYNC_STAGES+1 clk edges after the edge that first samples pwm_in at the closing active edge.
REQ-025 timeout != 0 and cnt >= timeout in HIGH or LOW -> STUCK, stuck <= 1, stuck_level <= level, no valid.
REQ-026 Edge and timeout in same cycle: edge wins, timeout ignored.
REQ-027 STUCK: rise -> HIGH (cnt <= 1, stuck <= 0, no valid for that edge); fall -> ARM (stuck <= 0).
REQ-028 Minimum measurable pulse 1 cycle (post-sync); shorter input glitches undefined.
REQ-029 Comparisons unsigned; cnt, hcap, period, high_time all COUNTER_WIDTH bits.

Reset
REQ-030 rst: sync flops, prev_level, cnt, hcap, sat = 0; FSM IDLE; period, high_time, valid, stuck, stuck_level = 0.
REQ-031 rst mid-measurement aborts immediately; no valid on release.

Structure
REQ-032 Shared package pwm_pkg: COUNTER_WIDTH default, FSM state encoding, shared with PWM generator.
REQ-033 One sub-module pwm_sync_edge: SYNC_STAGES synchronizer, polarity XOR, prev_level, rise/fall outputs; FSM and counters stay in pwm_capture.

Verification
REQ-034 polarity=0, timeout=0, pwm_in 30 high / 70 low repeating -> valid each period after first full cycle, period=100, high_time=30.
REQ-035 polarity=1, same waveform -> period=100, high_time=70.
REQ-036 timeout=50, pwm_in held high after a rise -> stuck=1, stuck_level=1 at 50 cycles, no valid; next rise -> stuck=0, following period measured correctly, no valid on recovery edge.
REQ-037 Reset with pwm_in high, polarity=0, release, en=1 -> no valid until low then two rises; first valid reports correct period.
REQ-038 en dropped at cycle 40 of 100-cycle period, re-raised -> no valid from aborted period; outputs hold prior values.
REQ-039 COUNTER_WIDTH=8, timeout=0, period 300 -> sat set, no valid; period 200 afterwards -> valid, period=200.

Source files
------------

// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the PWM blocks (capture and generator).
//   COUNTER_WIDTH_DEF : default width of cycle counters and measurements
//   SYNC_STAGES_MIN   : smallest legal synchronizer depth
//   pwm_state_t       : capture FSM state encoding
// -----------------------------------------------------------------------------
package pwm_pkg;

  localparam int COUNTER_WIDTH_DEF = 32;
  localparam int SYNC_STAGES_MIN   = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_STUCK = 3'd4
  } pwm_state_t;

endpackage

// File: rtl/pwm_sync_edge.sv
// -----------------------------------------------------------------------------
// pwm_sync_edge
// Brings the asynchronous PWM input into the clk domain, applies polarity and
// produces registered rise/fall strobes of the active level.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   pwm_in    : asynchronous PWM gate signal
//   polarity  : 0 = active high, 1 = active low
//   level_p1  : active level, aligned with rise_p1/fall_p1
//   rise_p1   : one-cycle strobe, active level went 0 -> 1
//   fall_p1   : one-cycle strobe, active level went 1 -> 0
// -----------------------------------------------------------------------------
module pwm_sync_edge
  import pwm_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_MIN
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  input  logic polarity,
  output logic level_p1,
  output logic rise_p1,
  output logic fall_p1
);

  logic [SYNC_STAGES-1:0] sync_q;
  // Marks which synchronizer/history flops already hold a real sample. The
  // reset value of the flops is not a real low, so edges are ignored until
  // both the synchronizer output and prev_level have been filled.
  logic [SYNC_STAGES:0]   fill_q;
  logic                   prev_level;
  logic                   level_p0;
  logic                   primed;

  assign level_p0 = sync_q[SYNC_STAGES-1] ^ polarity;
  assign primed   = fill_q[SYNC_STAGES];
  assign level_p1 = prev_level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      fill_q     <= '0;
      prev_level <= 1'b0;
      rise_p1    <= 1'b0;
      fall_p1    <= 1'b0;
    end else begin
      // Stage p0: synchronizer chain
      sync_q     <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      fill_q     <= {fill_q[SYNC_STAGES-1:0], 1'b1};
      // Stage p1: edge detect against the previous active level
      prev_level <= level_p0;
      rise_p1    <= primed &  level_p0 & ~prev_level;
      fall_p1    <= primed & ~level_p0 &  prev_level;
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// -----------------------------------------------------------------------------
// pwm_capture
// Measures period (active edge to active edge) and active-level duration of a
// PWM signal in clk cycles, and flags a stuck input when no edge arrives
// within a programmable number of cycles.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   en          : capture enable, low returns to IDLE and drops the measurement
//   polarity    : 0 = active high, 1 = active low (change only while en=0)
//   pwm_in      : asynchronous PWM input
//   timeout     : stuck-detect limit in cycles, 0 disables
//   period      : last measured period
//   high_time   : last measured active-level duration
//   valid       : one-cycle pulse when period/high_time update
//   stuck       : no edge seen within timeout cycles
//   stuck_level : active level at the moment stuck was entered
// -----------------------------------------------------------------------------
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int COUNTER_WIDTH = COUNTER_WIDTH_DEF,
  parameter int SYNC_STAGES   = SYNC_STAGES_MIN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     polarity,
  input  logic                     pwm_in,
  input  logic [COUNTER_WIDTH-1:0] timeout,
  output logic [COUNTER_WIDTH-1:0] period,
  output logic [COUNTER_WIDTH-1:0] high_time,
  output logic                     valid,
  output logic                     stuck,
  output logic                     stuck_level
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

  pwm_state_t               state;
  logic [COUNTER_WIDTH-1:0] cnt;
  logic [COUNTER_WIDTH-1:0] hcap;
  logic                     sat;

  logic                     level_p1;
  logic                     rise_p1;
  logic                     fall_p1;

  logic [COUNTER_WIDTH-1:0] cnt_inc;
  logic                     cnt_at_max;
  logic                     timed_out;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [COUNTER_WIDTH-1:0] sat_inc(
    input logic [COUNTER_WIDTH-1:0] v
  );
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  pwm_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk      (clk),
    .rst      (rst),
    .pwm_in   (pwm_in),
    .polarity (polarity),
    .level_p1 (level_p1),
    .rise_p1  (rise_p1),
    .fall_p1  (fall_p1)
  );

  assign cnt_inc    = sat_inc(cnt);
  // An increment attempted at all-ones means the true count no longer fits.
  assign cnt_at_max = (cnt == CNT_MAX);
  assign timed_out  = (timeout != '0) && (cnt >= timeout);

  // Stage p2: measurement FSM, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      hcap        <= '0;
      sat         <= 1'b0;
      period      <= '0;
      high_time   <= '0;
      valid       <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (!en) begin
        state <= ST_IDLE;
        stuck <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_ARM;
          end

          // Only a genuine low-to-high transition starts a measurement; a
          // level that is already active when arming has to drop first.
          ST_ARM: begin
            if (rise_p1) begin
              state <= ST_HIGH;
              cnt   <= CNT_ONE;
              sat   <= 1'b0;
            end
          end

          ST_HIGH: begin
            if (fall_p1) begin
              hcap  <= cnt;
              cnt   <= cnt_inc;
              sat   <= sat | cnt_at_max;
              state <= ST_LOW;
            end else if (timed_out) begin
              state       <= ST_STUCK;
              stuck       <= 1'b1;
              stuck_level <= level_p1;
            end else begin
              cnt <= cnt_inc;
              sat <= sat | cnt_at_max;
            end
          end

          // The closing rise also opens the next measurement, so periods are
          // back-to-back with no lost cycle.
          ST_LOW: begin
            if (rise_p1) begin
              if (!sat) begin
                period    <= cnt;
                high_time <= hcap;
                valid     <= 1'b1;
              end
              cnt   <= CNT_ONE;
              sat   <= 1'b0;
              state <= ST_HIGH;
            end else if (timed_out) begin
              state       <= ST_STUCK;
              stuck       <= 1'b1;
              stuck_level <= level_p1;
            end else begin
              cnt <= cnt_inc;
              sat <= sat | cnt_at_max;
            end
          end

          // A rise restarts counting directly; the half period before it is
          // unknown, so that edge produces no result.
          ST_STUCK: begin
            if (rise_p1) begin
              state <= ST_HIGH;
              cnt   <= CNT_ONE;
              sat   <= 1'b0;
              stuck <= 1'b0;
            end else if (fall_p1) begin
              state <= ST_ARM;
              stuck <= 1'b0;
            end
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
module tb_pwm_capture;

  typedef struct {
    logic [31:0] p;
    logic [31:0] h;
  } meas_t;

  typedef struct {
    logic        pol;
    int          act;
    int          inact;
    int          n;
    logic [31:0] exp_p;
    logic [31:0] exp_h;
    bit          ok8;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic        polarity;
  logic        pwm_in;
  logic [31:0] timeout;

  logic [31:0] period32;
  logic [31:0] high32;
  logic        valid32;
  logic        stuck32;
  logic        stuck_level32;

  logic [7:0]  period8;
  logic [7:0]  high8;
  logic        valid8;
  logic        stuck8;
  logic        stuck_level8;

  int n_tests = 0;
  int n_fail  = 0;

  meas_t q32[$];
  meas_t q8[$];
  vec_t  vecs[7];

  pwm_capture #(
    .COUNTER_WIDTH (32),
    .SYNC_STAGES   (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .polarity    (polarity),
    .pwm_in      (pwm_in),
    .timeout     (timeout),
    .period      (period32),
    .high_time   (high32),
    .valid       (valid32),
    .stuck       (stuck32),
    .stuck_level (stuck_level32)
  );

  pwm_capture #(
    .COUNTER_WIDTH (8),
    .SYNC_STAGES   (2)
  ) dut8 (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .polarity    (polarity),
    .pwm_in      (pwm_in),
    .timeout     (timeout[7:0]),
    .period      (period8),
    .high_time   (high8),
    .valid       (valid8),
    .stuck       (stuck8),
    .stuck_level (stuck_level8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pwm(input logic v, input int n);
    pwm_in = v;
    cyc(n);
  endtask

  task automatic expect_meas(input logic [31:0] ep, input logic [31:0] eh, input bit ok8);
    meas_t m;
    m.p = ep;
    m.h = eh;
    q32.push_back(m);
    if (ok8) q8.push_back(m);
  endtask

  task automatic settle(input string name);
    cyc(10);
    check({name, "_q32_drained"}, 32'(q32.size()), 32'd0);
    check({name, "_q8_drained"}, 32'(q8.size()), 32'd0);
  endtask

  // Scoreboard: every valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    meas_t e;
    if (valid32) begin
      n_tests++;
      if (q32.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid32: got period=%0d high=%0d, expected no valid", period32, high32);
      end else begin
        e = q32.pop_front();
        if (period32 !== e.p || high32 !== e.h) begin
          n_fail++;
          $display("FAIL meas32: got period=%0d high=%0d, expected period=%0d high=%0d",
                   period32, high32, e.p, e.h);
        end
      end
    end
  end

  always @(negedge clk) begin
    meas_t e;
    if (valid8) begin
      n_tests++;
      if (q8.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid8: got period=%0d high=%0d, expected no valid", period8, high8);
      end else begin
        e = q8.pop_front();
        if ({24'd0, period8} !== e.p || {24'd0, high8} !== e.h) begin
          n_fail++;
          $display("FAIL meas8: got period=%0d high=%0d, expected period=%0d high=%0d",
                   period8, high8, e.p, e.h);
        end
      end
    end
  end

  initial begin
    // pol, active cycles, inactive cycles, periods, period, high_time, fits 8 bit
    vecs[0] = '{1'b0, 30,  70, 3, 32'd100, 32'd30, 1'b1};
    vecs[1] = '{1'b1, 70,  30, 3, 32'd100, 32'd70, 1'b1};
    vecs[2] = '{1'b0,  1,   1, 3, 32'd2,   32'd1,  1'b1};
    vecs[3] = '{1'b1,  5,  12, 2, 32'd17,  32'd5,  1'b1};
    vecs[4] = '{1'b0,  5, 250, 1, 32'd255, 32'd5,  1'b1};
    vecs[5] = '{1'b0,  6, 250, 1, 32'd256, 32'd6,  1'b0};
    vecs[6] = '{1'b1,  3,  40, 2, 32'd43,  32'd3,  1'b1};

    rst      = 1'b1;
    en       = 1'b0;
    polarity = 1'b0;
    pwm_in   = 1'b0;
    timeout  = 32'd0;
    cyc(2);
    check("rst_period",      period32,      32'd0);
    check("rst_high_time",   high32,        32'd0);
    check("rst_valid",       {31'd0, valid32}, 32'd0);
    check("rst_stuck",       {31'd0, stuck32}, 32'd0);
    check("rst_stuck_level", {31'd0, stuck_level32}, 32'd0);
    check("rst_period8",     {24'd0, period8}, 32'd0);
    rst = 1'b0;
    cyc(5);

    // Table-driven periodic waveforms
    for (int v = 0; v < 7; v++) begin
      en = 1'b0;
      cyc(3);
      polarity = vecs[v].pol;
      timeout  = 32'd0;
      pwm_in   = vecs[v].pol;
      cyc(5);
      en = 1'b1;
      cyc(5);
      for (int i = 0; i < vecs[v].n; i++) expect_meas(vecs[v].exp_p, vecs[v].exp_h, vecs[v].ok8);
      for (int i = 0; i < vecs[v].n; i++) begin
        set_pwm(!vecs[v].pol, vecs[v].act);
        set_pwm(vecs[v].pol, vecs[v].inact);
      end
      set_pwm(!vecs[v].pol, vecs[v].act);
      set_pwm(vecs[v].pol, 3);
      settle($sformatf("vec%0d", v));
    end

    // Saturation in the narrow counter, then recovery on the next period
    en = 1'b0;
    cyc(3);
    polarity = 1'b0;
    pwm_in   = 1'b0;
    cyc(3);
    en = 1'b1;
    cyc(5);
    expect_meas(32'd300, 32'd100, 1'b0);
    expect_meas(32'd200, 32'd50,  1'b1);
    set_pwm(1'b1, 100);
    set_pwm(1'b0, 200);
    set_pwm(1'b1, 50);
    set_pwm(1'b0, 150);
    set_pwm(1'b1, 5);
    set_pwm(1'b0, 3);
    settle("sat");

    // Stuck high, fall recovery, stuck low, rise recovery
    en = 1'b0;
    cyc(3);
    timeout = 32'd50;
    pwm_in  = 1'b0;
    en = 1'b1;
    cyc(5);
    set_pwm(1'b1, 30);
    check("stuck_hi_early", {31'd0, stuck32}, 32'd0);
    cyc(50);
    check("stuck_hi",        {31'd0, stuck32},       32'd1);
    check("stuck_hi_level",  {31'd0, stuck_level32}, 32'd1);
    check("stuck_hi8",       {31'd0, stuck8},        32'd1);
    expect_meas(32'd35, 32'd10, 1'b1);
    expect_meas(32'd35, 32'd10, 1'b1);
    set_pwm(1'b0, 20);
    check("stuck_hi_cleared", {31'd0, stuck32}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      set_pwm(1'b1, 10);
      set_pwm(1'b0, 25);
    end
    set_pwm(1'b1, 10);
    set_pwm(1'b0, 20);
    check("stuck_lo_early", {31'd0, stuck32}, 32'd0);
    cyc(60);
    check("stuck_lo",       {31'd0, stuck32},       32'd1);
    check("stuck_lo_level", {31'd0, stuck_level32}, 32'd0);
    expect_meas(32'd35, 32'd10, 1'b1);
    expect_meas(32'd35, 32'd10, 1'b1);
    for (int i = 0; i < 2; i++) begin
      set_pwm(1'b1, 10);
      set_pwm(1'b0, 25);
    end
    check("stuck_lo_cleared", {31'd0, stuck32}, 32'd0);
    set_pwm(1'b1, 10);
    set_pwm(1'b0, 5);
    settle("stuck");
    timeout = 32'd0;

    // Reset in the middle of a measurement, released with the input high
    en = 1'b0;
    cyc(3);
    pwm_in = 1'b0;
    en = 1'b1;
    cyc(5);
    set_pwm(1'b1, 15);
    #2 rst = 1'b1;
    @(negedge clk);
    check("mid_rst_period",    period32, 32'd0);
    check("mid_rst_high_time", high32,   32'd0);
    check("mid_rst_valid",     {31'd0, valid32}, 32'd0);
    check("mid_rst_period8",   {24'd0, period8}, 32'd0);
    cyc(2);
    rst = 1'b0;
    cyc(20);
    expect_meas(32'd100, 32'd30, 1'b1);
    set_pwm(1'b0, 40);
    set_pwm(1'b1, 30);
    set_pwm(1'b0, 70);
    set_pwm(1'b1, 5);
    set_pwm(1'b0, 3);
    settle("rst_release");

    // Enable dropped 40 cycles into a period; results must hold
    en = 1'b0;
    cyc(3);
    en = 1'b1;
    cyc(5);
    expect_meas(32'd100, 32'd30, 1'b1);
    set_pwm(1'b1, 30);
    set_pwm(1'b0, 70);
    set_pwm(1'b1, 30);
    set_pwm(1'b0, 10);
    en = 1'b0;
    cyc(5);
    check("en_drop_period_hold",    period32, 32'd100);
    check("en_drop_high_hold",      high32,   32'd30);
    check("en_drop_stuck",          {31'd0, stuck32}, 32'd0);
    en = 1'b1;
    cyc(55);
    check("en_resume_period_hold",  period32, 32'd100);
    expect_meas(32'd80, 32'd20, 1'b1);
    set_pwm(1'b1, 20);
    set_pwm(1'b0, 60);
    // Closing edge: valid appears on the fourth falling clock edge after drive
    pwm_in = 1'b1;
    cyc(3);
    check("latency_not_yet", {31'd0, valid32}, 32'd0);
    cyc(1);
    check("latency_valid",   {31'd0, valid32}, 32'd1);
    cyc(1);
    check("valid_one_cycle", {31'd0, valid32}, 32'd0);
    cyc(5);
    pwm_in = 1'b0;
    settle("en_drop");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
